// File: rtl/skeleton_line_renderer.sv
`default_nettype none
// ============================================================================
// Module      : skeleton_line_renderer
// Description : Draws the three connected segments P1->P2, P2->P3, P3->P4 of a
//               decoded pose frame with Bresenham's algorithm. Each in-bounds
//               pixel is offered on a valid/ready write port.
// Ports       : clk, reset_n (async, active-low)
//               done            - frame-ready level, asynchronous to clk
//               x_1..y_4        - joint coordinates (stable while done high)
//               r, g, b         - segment colour
//               pix_valid/ready - pixel write handshake
//               pix_x, pix_y    - pixel position, pix_rgb - latched colour
//               busy            - not idle, frame_done - end-of-frame pulse
// Revision    : 1.0 - initial release
// ============================================================================
module skeleton_line_renderer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        done,
    input  logic [9:0]  x_1,
    input  logic [9:0]  y_1,
    input  logic [9:0]  x_2,
    input  logic [9:0]  y_2,
    input  logic [9:0]  x_3,
    input  logic [9:0]  y_3,
    input  logic [9:0]  x_4,
    input  logic [9:0]  y_4,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [10:0] C_H_LIM = 11'(H_RES);
    localparam logic [10:0] C_V_LIM = 11'(V_RES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_DRAW  = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // done synchroniser and edge detector
    logic r_s1, r_s2, r_s3;
    logic w_start;

    logic              r_pending;
    logic [9:0]        r_px [0:3];
    logic [9:0]        r_py [0:3];
    logic [11:0]       r_rgb;
    logic [1:0]        r_seg;
    logic [9:0]        r_end_x, r_end_y;
    logic signed [11:0] r_dx, r_dy, r_err;
    logic              r_sx_neg, r_sy_neg;
    logic [9:0]        r_cur_x, r_cur_y;

    logic [9:0]        w_x0, w_y0, w_x1, w_y1;
    logic [9:0]        w_adx, w_ady;
    logic signed [12:0] w_e2, w_dx13, w_dy13;
    logic              w_step_x, w_step_y;
    logic              w_in_bounds, w_advance, w_at_end;

    assign w_start = r_s2 & ~r_s3;

    // Endpoints of the current segment: joint seg to joint seg+1.
    assign w_x0 = r_px[r_seg];
    assign w_y0 = r_py[r_seg];
    assign w_x1 = r_px[r_seg + 2'd1];
    assign w_y1 = r_py[r_seg + 2'd1];
    assign w_adx = (w_x1 >= w_x0) ? (w_x1 - w_x0) : (w_x0 - w_x1);
    assign w_ady = (w_y1 >= w_y0) ? (w_y1 - w_y0) : (w_y0 - w_y1);

    // Both error tests use the pre-update err so a diagonal step is one cycle.
    assign w_e2     = {r_err, 1'b0};
    assign w_dx13   = {r_dx[11], r_dx};
    assign w_dy13   = {r_dy[11], r_dy};
    assign w_step_x = (w_e2 >= w_dy13);
    assign w_step_y = (w_e2 <= w_dx13);

    assign w_in_bounds = ({1'b0, r_cur_x} < C_H_LIM) && ({1'b0, r_cur_y} < C_V_LIM);
    // Off-screen pixels are skipped without waiting for the sink.
    assign w_advance   = (r_state == S_DRAW) && (!w_in_bounds || pix_ready);
    assign w_at_end    = (r_cur_x == r_end_x) && (r_cur_y == r_end_y);

    // Outputs come straight from registers; pix_valid never sees pix_ready.
    assign pix_valid  = (r_state == S_DRAW) && w_in_bounds;
    assign pix_x      = r_cur_x;
    assign pix_y      = r_cur_y;
    assign pix_rgb    = r_rgb;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start || r_pending) w_state_next = S_SETUP;
            S_SETUP: w_state_next = S_DRAW;
            S_DRAW:  if (w_advance && w_at_end) w_state_next = S_NEXT;
            S_NEXT:  w_state_next = (r_seg == 2'd2) ? S_DONE : S_SETUP;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_pending <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_px[i] <= '0;
                r_py[i] <= '0;
            end
            r_rgb    <= '0;
            r_seg    <= '0;
            r_end_x  <= '0;
            r_end_y  <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_cur_x  <= '0;
            r_cur_y  <= '0;
        end else begin
            r_s1 <= done;
            r_s2 <= r_s1;
            r_s3 <= r_s2;

            // A start seen while busy is remembered once; the frame it
            // triggers samples the inputs only when it actually begins.
            if (r_state != S_IDLE && w_start) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start || r_pending) begin
                        r_px[0]   <= x_1;
                        r_py[0]   <= y_1;
                        r_px[1]   <= x_2;
                        r_py[1]   <= y_2;
                        r_px[2]   <= x_3;
                        r_py[2]   <= y_3;
                        r_px[3]   <= x_4;
                        r_py[3]   <= y_4;
                        r_rgb     <= {r, g, b};
                        r_seg     <= 2'd0;
                        r_pending <= 1'b0;
                    end
                end
                S_SETUP: begin
                    r_end_x  <= w_x1;
                    r_end_y  <= w_y1;
                    r_dx     <= $signed({2'b00, w_adx});
                    r_dy     <= -$signed({2'b00, w_ady});
                    r_err    <= $signed({2'b00, w_adx}) - $signed({2'b00, w_ady});
                    r_sx_neg <= !(w_x0 < w_x1);
                    r_sy_neg <= !(w_y0 < w_y1);
                    r_cur_x  <= w_x0;
                    r_cur_y  <= w_y0;
                end
                S_DRAW: begin
                    if (w_advance && !w_at_end) begin
                        r_err <= r_err + (w_step_x ? r_dy : 12'sd0)
                                       + (w_step_y ? r_dx : 12'sd0);
                        if (w_step_x) begin
                            r_cur_x <= r_sx_neg ? (r_cur_x - 10'd1) : (r_cur_x + 10'd1);
                        end
                        if (w_step_y) begin
                            r_cur_y <= r_sy_neg ? (r_cur_y - 10'd1) : (r_cur_y + 10'd1);
                        end
                    end
                end
                S_NEXT: begin
                    if (r_seg != 2'd2) begin
                        r_seg <= r_seg + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_skeleton_line_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_skeleton_line_renderer
// Description : Self-checking bench for skeleton_line_renderer. A Bresenham
//               reference model fills an expected-pixel queue per frame; a
//               monitor compares every accepted pixel, stall stability and
//               frame_done placement against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skeleton_line_renderer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        done;
    logic [9:0]  x_1, y_1, x_2, y_2, x_3, y_3, x_4, y_4;
    logic [3:0]  r, g, b;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x, pix_y;
    logic [11:0] pix_rgb;
    logic        busy;
    logic        frame_done;

    skeleton_line_renderer dut (
        .clk(clk), .reset_n(reset_n), .done(done),
        .x_1(x_1), .y_1(y_1), .x_2(x_2), .y_2(y_2),
        .x_3(x_3), .y_3(y_3), .x_4(x_4), .y_4(y_4),
        .r(r), .g(g), .b(b),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .busy(busy), .frame_done(frame_done)
    );

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int fd_count = 0;
    int acc_count = 0;
    int ready_mode = 0;

    // Entry: {frame_end_marker, rgb[11:0], x[9:0], y[9:0]}
    logic [32:0] exp_q[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: textbook Bresenham per segment, clipped to 640x480.
    function automatic int model_frame(input int xs[4], input int ys[4], input logic [11:0] c);
        int n = 0;
        for (int s = 0; s < 3; s++) begin
            int x, y, xe, ye, dx, dy, sx, sy, err, e2;
            x  = xs[s];   y  = ys[s];
            xe = xs[s+1]; ye = ys[s+1];
            dx = (xe > x) ? xe - x : x - xe;
            dy = -((ye > y) ? ye - y : y - ye);
            sx = (x < xe) ? 1 : -1;
            sy = (y < ye) ? 1 : -1;
            err = dx + dy;
            for (int guard = 0; guard < 4096; guard++) begin
                if (x < 640 && y < 480) begin
                    exp_q.push_back({1'b0, c, 10'(x), 10'(y)});
                    n++;
                end
                if (x == xe && y == ye) break;
                e2 = 2 * err;
                if (e2 >= dy) begin err += dy; x += sx; end
                if (e2 <= dx) begin err += dx; y += sy; end
            end
        end
        exp_q.push_back({1'b1, 32'd0});
        return n;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_pose(input int xs[4], input int ys[4], input logic [11:0] c);
        x_1 = 10'(xs[0]); y_1 = 10'(ys[0]);
        x_2 = 10'(xs[1]); y_2 = 10'(ys[1]);
        x_3 = 10'(xs[2]); y_3 = 10'(ys[2]);
        x_4 = 10'(xs[3]); y_4 = 10'(ys[3]);
        {r, g, b} = c;
    endtask

    // Drop done, load a pose, queue its expected pixels, raise done.
    task automatic new_frame(input int xs[4], input int ys[4], input logic [11:0] c, output int n);
        done = 1'b0;
        tick(4);
        set_pose(xs, ys, c);
        n = model_frame(xs, ys, c);
        done = 1'b1;
    endtask

    task automatic wait_frames(input int target, input string nm);
        int k = 0;
        while (fd_count < target && k < 3000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(nm, 64'(fd_count), 64'(target));
    endtask

    // Sink: pix_ready always high, or the repeating pattern 1-0-0-1.
    initial begin
        int rcnt = 0;
        logic [3:0] rpat = 4'b1001;
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pix_ready = (ready_mode == 0) ? 1'b1 : rpat[rcnt % 4];
            rcnt++;
        end
    end

    // Monitor, sampled on the falling edge.
    initial begin
        logic        prev_stall = 1'b0;
        logic [31:0] prev_word  = '0;
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_held", 64'(pix_valid), 64'd1);
                    check("stall_outputs_held", 64'({pix_x, pix_y, pix_rgb}), 64'(prev_word));
                end
                if (pix_valid && pix_ready) begin
                    if (exp_q.size() == 0 || exp_q[0][32]) begin
                        check("unexpected_pixel", 64'({pix_x, pix_y}), 64'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel", 64'({pix_rgb, pix_x, pix_y}), 64'(e[31:0]));
                        acc_count++;
                    end
                end
                if (frame_done) begin
                    fd_count++;
                    check("frame_done_at_frame_end",
                          64'((exp_q.size() != 0) && exp_q[0][32]), 64'd1);
                    if (exp_q.size() != 0 && exp_q[0][32]) void'(exp_q.pop_front());
                end
                prev_stall = pix_valid && !pix_ready;
                prev_word  = {pix_x, pix_y, pix_rgb};
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int ax[4], ay[4], dgx[4], dgy[4], cx[4], cy[4];
        int lx[13], ly[13];
        int n, base, first_k, fd_save;
        logic [32:0] e;

        ax  = '{10, 14, 14, 11};  ay  = '{20, 20, 23, 20};
        dgx = '{5, 5, 5, 5};      dgy = '{5, 5, 5, 5};
        cx  = '{636, 643, 643, 643}; cy = '{0, 0, 0, 0};
        lx  = '{10, 11, 12, 13, 14, 14, 14, 14, 14, 14, 13, 12, 11};
        ly  = '{20, 20, 20, 20, 20, 20, 21, 22, 23, 23, 22, 21, 20};

        reset_n = 1'b0;
        done    = 1'b0;
        set_pose(dgx, dgy, 12'h000);
        #1;
        check("reset_pix_valid", 64'(pix_valid), 64'd0);
        check("reset_pix_x", 64'(pix_x), 64'd0);
        check("reset_pix_y", 64'(pix_y), 64'd0);
        check("reset_pix_rgb", 64'(pix_rgb), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_frame_done", 64'(frame_done), 64'd0);
        tick(3);
        reset_n = 1'b1;
        tick(3);

        // Connected pose: pin the model to the hand-derived pixel list.
        new_frame(ax, ay, 12'hF0A, n);
        check("model_count_connected", 64'(n), 64'd13);
        base = exp_q.size() - n - 1;
        for (int i = 0; i < 13; i++) begin
            e = exp_q[base + i];
            check("model_pixel_connected", 64'(e[31:0]), 64'({12'hF0A, 10'(lx[i]), 10'(ly[i])}));
        end
        first_k = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (pix_valid && first_k == 0) first_k = k;
        end
        check("first_valid_latency", 64'(first_k), 64'd4);
        wait_frames(1, "frame_done_connected");

        // Degenerate pose: three copies of the same pixel.
        new_frame(dgx, dgy, 12'h123, n);
        check("model_count_degenerate", 64'(n), 64'd3);
        wait_frames(2, "frame_done_degenerate");

        // Backpressure with the 1-0-0-1 ready pattern.
        ready_mode = 1;
        new_frame(ax, ay, 12'hF0A, n);
        wait_frames(3, "frame_done_backpressure");
        ready_mode = 0;

        // Clipping at the right edge.
        new_frame(cx, cy, 12'h0F0, n);
        check("model_count_clipped", 64'(n), 64'd4);
        wait_frames(4, "frame_done_clipped");

        // Overrun: two more edges during frame 1; pose changes before the
        // pending frame starts, so the second frame must use the new pose.
        new_frame(ax, ay, 12'hF0A, n);
        tick(4);  done = 1'b0;
        tick(3);  done = 1'b1;
        tick(3);  done = 1'b0;
        set_pose(cx, cy, 12'h00F);
        n = model_frame(cx, cy, 12'h00F);
        tick(3);  done = 1'b1;
        wait_frames(6, "frame_done_overrun");
        tick(60);
        check("overrun_no_third_frame", 64'(fd_count), 64'd6);
        check("overrun_idle", 64'(busy), 64'd0);

        // Reset after the fifth accepted pixel.
        new_frame(ax, ay, 12'hF0A, n);
        base = acc_count;
        for (int k = 0; k < 200 && acc_count < base + 5; k++) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_accepted", 64'(acc_count - base), 64'd5);
        check("midreset_pix_valid", 64'(pix_valid), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_pix_rgb", 64'(pix_rgb), 64'd0);
        exp_q.delete();
        fd_save = fd_count;
        done = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(5);
        check("midreset_no_frame_done", 64'(fd_count), 64'(fd_save));
        new_frame(ax, ay, 12'hF0A, n);
        wait_frames(fd_save + 1, "frame_done_after_reset");

        // done held high across reset release counts as one new frame.
        tick(2);
        reset_n = 1'b0;
        tick(2);
        n = model_frame(ax, ay, 12'hF0A);
        reset_n = 1'b1;
        wait_frames(fd_save + 2, "frame_done_done_held");
        tick(40);
        check("done_held_single_frame", 64'(fd_count), 64'(fd_save + 2));
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
